// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
// Bus direction encoding and pad-enable pattern live here.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        XFER
    } state_e;

    localparam logic       DIR_IN     = 1'b0;
    localparam logic       DIR_OUT    = 1'b1;
    localparam logic [7:0] PAD_OE_ALL = 8'hFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i.
// Produces a one-hot winner and a valid flag.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    int best;
    int d;

    always_comb begin
        gnt_o   = '0;
        valid_o = |req_i;
        best    = N;
        d       = 0;
        // Smallest forward distance from the pointer wins.
        for (int i = 0; i < N; i++) begin
            d = (i + N - int'(ptr_i)) % N;
            if (req_i[i] && d < best) begin
                best     = d;
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_port_arbiter.sv
// Round-robin sequencer sharing the bidirectional uio pads between
// requesters, with a tri-state gap on every bus direction change.
module uio_port_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int LEN_W      = 2,
    parameter int TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_dir,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic [NUM_REQ*8-1:0]     wr_data,
    input  logic [7:0]               uio_in,
    output logic [7:0]               uio_out,
    output logic [7:0]               uio_oe,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     beat,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (LEN_W > 2) ? LEN_W : 2;

    state_e             state_q, state_d;
    logic [PW-1:0]      win_q, win_d;
    logic               dir_q, dir_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic               bus_dir_q, bus_dir_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic [PW-1:0]      pick_idx;
    logic               pick_dir;
    logic [LEN_W-1:0]   pick_len;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_req;
    logic [7:0]         win_wr;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rr_q),
        .gnt_o   (pick_oh),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        pick_dir = 1'b0;
        pick_len = '0;
        win_oh   = '0;
        win_req  = 1'b0;
        win_wr   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PW'(i);
                pick_dir = req_dir[i];
                pick_len = req_len[i*LEN_W +: LEN_W];
            end
            if (win_q == PW'(i)) begin
                win_oh[i] = 1'b1;
                win_req   = req[i];
                win_wr    = wr_data[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        dir_d     = dir_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        bus_dir_d = bus_dir_q;
        gnt       = '0;
        beat      = 1'b0;
        uio_out   = '0;
        uio_oe    = '0;
        unique case (state_q)
            IDLE: begin
                if (ena && pick_valid) begin
                    win_d = pick_idx;
                    dir_d = pick_dir;
                    len_d = pick_len;
                    if (pick_dir != bus_dir_q) begin
                        state_d = TURN;
                        cnt_d   = CW'(TURNAROUND - 1);
                    end else begin
                        state_d = XFER;
                        cnt_d   = CW'(pick_len);
                    end
                end
            end
            TURN: begin
                if (cnt_q == '0) begin
                    state_d   = XFER;
                    bus_dir_d = dir_q;
                    cnt_d     = CW'(len_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            XFER: begin
                gnt   = win_oh;
                beat  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (dir_q == DIR_OUT) begin
                    uio_out = win_wr;
                    uio_oe  = PAD_OE_ALL;
                end
                // A dropped request ends the burst on this beat.
                if (cnt_q == '0 || !win_req) begin
                    state_d = IDLE;
                    rr_d    = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_valid_d = (state_q == XFER) && (dir_q == DIR_IN);
    assign rd_data_d  = rd_valid_d ? uio_in : rd_data_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= '0;
            dir_q      <= DIR_IN;
            len_q      <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
            bus_dir_q  <= DIR_IN;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            dir_q      <= dir_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            bus_dir_q  <= bus_dir_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_uio_port_arbiter.sv
// Randomized bench for uio_port_arbiter against a burst-level model.
// Model tracks remaining turnaround and beat counts per grant.
module tb_uio_port_arbiter;

    localparam int N  = 3;
    localparam int LW = 2;
    localparam int TA = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [N-1:0]  req;
    logic [N-1:0]  req_dir;
    logic [N*LW-1:0] req_len;
    logic [N*8-1:0]  wr_data;
    logic [7:0]    uio_in;
    logic [7:0]    uio_out;
    logic [7:0]    uio_oe;
    logic [N-1:0]  gnt;
    logic          beat;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          busy;

    always #5 clk = ~clk;

    uio_port_arbiter #(
        .NUM_REQ    (N),
        .LEN_W      (LW),
        .TURNAROUND (TA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .req      (req),
        .req_dir  (req_dir),
        .req_len  (req_len),
        .wr_data  (wr_data),
        .uio_in   (uio_in),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe),
        .gnt      (gnt),
        .beat     (beat),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int         m_turn;
    int         m_left;
    int         m_win;
    int         m_rr;
    logic       m_dir;
    logic       m_bus;
    logic       m_rdv;
    logic [7:0] m_rdd;
    logic       m_prev_rd;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h",
                      tag, cyc, got, exp);
    endtask

    function automatic logic in_xfer();
        return (m_turn == 0) && (m_left > 0);
    endfunction

    task automatic model_edge();
        logic x;
        logic found;
        int   c;
        x = in_xfer();
        m_prev_rd = x && !m_dir && !rst;
        if (rst) begin
            m_turn = 0; m_left = 0; m_win = 0; m_rr = 0;
            m_dir = 1'b0; m_bus = 1'b0; m_rdv = 1'b0; m_rdd = 8'h00;
        end else begin
            m_rdv = x && !m_dir;
            if (m_rdv) m_rdd = uio_in;
            if (x) begin
                m_left--;
                if (m_left == 0 || ((req >> m_win) & 1) == 0) begin
                    m_left = 0;
                    m_rr   = (m_win + 1) % N;
                end
            end else if (m_turn > 0) begin
                m_turn--;
                if (m_turn == 0) m_bus = m_dir;
            end else if (ena && req != 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (!found && ((req >> c) & 1) != 0) begin
                        found = 1'b1;
                        m_win = c;
                    end
                end
                m_dir  = ((req_dir >> m_win) & 1) != 0;
                m_left = int'((req_len >> (m_win * LW)) & 2'b11) + 1;
                m_turn = (m_dir != m_bus) ? TA : 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic x;
        logic [7:0] wb;
        x  = in_xfer();
        wb = 8'(wr_data >> (m_win * 8));
        check("busy", busy, (m_turn > 0 || m_left > 0));
        check("gnt", gnt, x ? (1 << m_win) : 0);
        check("beat", beat, x);
        check("uio_oe", uio_oe, (x && m_dir) ? 8'hFF : 8'h00);
        check("uio_out", uio_out, (x && m_dir) ? wb : 8'h00);
        check("rd_valid", rd_valid, m_rdv);
        check("rd_data", rd_data, m_rdd);
        if (m_prev_rd) check("oe_after_read", uio_oe, 8'h00);
    endtask

    task automatic drive();
        if (cyc < 2) begin
            rst = 1'b1; ena = 1'b1; req = '1;
            req_dir = '0; req_len = '0;
        end else begin
            rst = ($urandom_range(0, 149) == 0);
            ena = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) begin
                if (req[i]) req[i] = ($urandom_range(0, 9) != 0);
                else        req[i] = ($urandom_range(0, 2) == 0);
            end
            req_dir = N'($urandom);
            req_len = (N*LW)'($urandom);
        end
        wr_data = (N*8)'({$urandom, $urandom});
        uio_in  = 8'($urandom);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; req = '1;
        req_dir = '0; req_len = '0; wr_data = '0; uio_in = '0;
        m_prev_rd = 1'b0;
        model_edge();
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            model_edge();
            drive();
            #1;
            check_outputs();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
